// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, requester ids,
// latency counter width and the memory size codes.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    // Size codes carried on the low nibble of the byte-code bus.
    localparam logic [3:0] MEM_BYT_1_S = 4'd1;
    localparam logic [3:0] MEM_BYT_1_U = 4'd2;
    localparam logic [3:0] MEM_BYT_2_S = 4'd3;
    localparam logic [3:0] MEM_BYT_2_U = 4'd4;
    localparam logic [3:0] MEM_BYT_4_S = 4'd5;
    localparam logic [3:0] MEM_BYT_4_U = 4'd6;
    localparam logic [3:0] MEM_BYT_8   = 4'd7;

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [3:0] byt);
        logic bad;
        bad = 1'b0;
        case (byt)
            MEM_BYT_2_S, MEM_BYT_2_U: bad = addr_lo[0];
            MEM_BYT_4_S, MEM_BYT_4_U: bad = |addr_lo[1:0];
            MEM_BYT_8:                bad = |addr_lo;
            default:                  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals of the shared memory port.
// slave is the arbiter's view; master is the requester/memory environment.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  ifu_valid;
    logic                  ifu_ready;
    logic [DATA_WIDTH-1:0] ifu_addr;
    logic                  ifu_resp_valid;
    logic [DATA_WIDTH-1:0] ifu_rd_data;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic                  lsu_wr_en;
    logic [DATA_WIDTH-1:0] lsu_addr;
    logic [DATA_WIDTH-1:0] lsu_wr_data;
    logic [DATA_WIDTH-1:0] lsu_wr_byt;
    logic                  lsu_resp_valid;
    logic [DATA_WIDTH-1:0] lsu_rd_data;
    logic                  lsu_err;

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_wr_byt;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  ifu_valid, ifu_addr,
        input  lsu_valid, lsu_wr_en, lsu_addr, lsu_wr_data, lsu_wr_byt,
        input  mem_rd_data,
        output ifu_ready, ifu_resp_valid, ifu_rd_data,
        output lsu_ready, lsu_resp_valid, lsu_rd_data, lsu_err,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_byt
    );

    modport master (
        output ifu_valid, ifu_addr,
        output lsu_valid, lsu_wr_en, lsu_addr, lsu_wr_data, lsu_wr_byt,
        output mem_rd_data,
        input  ifu_ready, ifu_resp_valid, ifu_rd_data,
        input  lsu_ready, lsu_resp_valid, lsu_rd_data, lsu_err,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_byt
    );
endinterface

// File: rtl/mem_arb_rr_picker.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module mem_arb_rr_picker
    import mem_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  req_id_e    last_grant,
    output logic [1:0] grant
);
    assign grant[0] = ifu_valid && (!lsu_valid || last_grant == REQ_LSU);
    assign grant[1] = lsu_valid && (!ifu_valid || last_grant == REQ_IFU);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU, one transaction at a time.
// Optional misaligned-LSU check enabled by defining MEM_ARB_ALIGN_CHK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_WIDTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] LAT_M1 = (MEM_LATENCY == 0) ? '0 : CNT_W'(MEM_LATENCY - 1);

    state_e                state_q;
    req_id_e               req_id_q;
    req_id_e               last_grant_q;
    logic                  we_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  mem_rd_en_q;
    logic                  mem_wr_en_q;
    logic [DATA_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wr_data_q;
    logic [DATA_WIDTH-1:0] mem_wr_byt_q;
    logic                  ifu_resp_q;
    logic                  lsu_resp_q;
    logic                  lsu_err_q;
    logic [DATA_WIDTH-1:0] ifu_rd_data_q;
    logic [DATA_WIDTH-1:0] lsu_rd_data_q;

    logic [1:0] grant;
    logic       accept;
    logic       win_lsu;
    logic       lsu_store;
    logic       misaligned;
    logic       enter_resp;

    mem_arb_rr_picker u_picker (
        .ifu_valid (bus.ifu_valid),
        .lsu_valid (bus.lsu_valid),
        .last_grant(last_grant_q),
        .grant     (grant)
    );

    assign accept    = (state_q == IDLE) && (grant != 2'b00);
    assign win_lsu   = grant[1];
    assign lsu_store = win_lsu && bus.lsu_wr_en;

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign misaligned = win_lsu && is_misaligned(bus.lsu_addr[2:0], bus.lsu_wr_byt[3:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign enter_resp = (state_q == ISSUE && MEM_LATENCY == 0) ||
                        (state_q == WAIT && cnt_q == '0);

    assign bus.ifu_ready = (state_q == IDLE) && grant[0];
    assign bus.lsu_ready = (state_q == IDLE) && grant[1];

    // NOTE: the async reset also drops any in-flight transaction; no response is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            req_id_q      <= REQ_IFU;
            last_grant_q  <= REQ_LSU;
            we_q          <= 1'b0;
            cnt_q         <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_wr_byt_q  <= '0;
            ifu_resp_q    <= 1'b0;
            lsu_resp_q    <= 1'b0;
            lsu_err_q     <= 1'b0;
            ifu_rd_data_q <= '0;
            lsu_rd_data_q <= '0;
        end else begin
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            lsu_err_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_id_q      <= win_lsu ? REQ_LSU : REQ_IFU;
                        last_grant_q  <= win_lsu ? REQ_LSU : REQ_IFU;
                        we_q          <= lsu_store;
                        mem_addr_q    <= win_lsu ? bus.lsu_addr : bus.ifu_addr;
                        mem_wr_data_q <= lsu_store ? bus.lsu_wr_data : '0;
                        mem_wr_byt_q  <= win_lsu ? bus.lsu_wr_byt : '0;
                        if (misaligned) begin
                            state_q       <= RESP;
                            lsu_resp_q    <= 1'b1;
                            lsu_err_q     <= 1'b1;
                            lsu_rd_data_q <= '0;
                        end else begin
                            state_q     <= ISSUE;
                            mem_rd_en_q <= !lsu_store;
                            mem_wr_en_q <= lsu_store;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= LAT_M1;
                    state_q <= (MEM_LATENCY == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) state_q <= RESP;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                RESP: begin
                    state_q       <= IDLE;
                    we_q          <= 1'b0;
                    mem_addr_q    <= '0;
                    mem_wr_data_q <= '0;
                    mem_wr_byt_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase

            // Read data is sampled on the edge that enters RESP.
            if (enter_resp) begin
                if (req_id_q == REQ_IFU) begin
                    ifu_resp_q    <= 1'b1;
                    ifu_rd_data_q <= bus.mem_rd_data;
                end else begin
                    lsu_resp_q    <= 1'b1;
                    lsu_rd_data_q <= we_q ? '0 : bus.mem_rd_data;
                end
            end
        end
    end

    assign bus.mem_rd_en      = mem_rd_en_q;
    assign bus.mem_wr_en      = mem_wr_en_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wr_data    = mem_wr_data_q;
    assign bus.mem_wr_byt     = mem_wr_byt_q;
    assign bus.ifu_resp_valid = ifu_resp_q;
    assign bus.ifu_rd_data    = ifu_rd_data_q;
    assign bus.lsu_resp_valid = lsu_resp_q;
    assign bus.lsu_rd_data    = lsu_rd_data_q;
    assign bus.lsu_err        = lsu_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LATENCY=1) with a one-cycle memory model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DW  = 64;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rd_cnt  = 0;
    int   wr_cnt  = 0;
    bit   dual_en = 1'b0;
    int   rd0;
    int   wr0;
    bit   exp_ifu;

    mem_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.MEM_LATENCY(LAT), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        return (a == 64'h8000_0000) ? 64'h13 : {a[31:0], ~a[31:0]};
    endfunction

    // Memory: data for a read enable appears one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_rd_data <= '0;
        end else begin
            if (bus.mem_rd_en) begin
                bus.mem_rd_data <= mem_model(bus.mem_addr);
                rd_cnt          <= rd_cnt + 1;
            end
            if (bus.mem_wr_en) wr_cnt <= wr_cnt + 1;
            if (bus.mem_rd_en && bus.mem_wr_en) dual_en <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.ifu_valid   = 1'b0;
        bus.ifu_addr    = '0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_wr_en   = 1'b0;
        bus.lsu_addr    = '0;
        bus.lsu_wr_data = '0;
        bus.lsu_wr_byt  = '0;

        // Reset state
        repeat (2) tick();
        check("rst_ifu_ready", bus.ifu_ready, 0);
        check("rst_lsu_ready", bus.lsu_ready, 0);
        check("rst_mem_en", {bus.mem_rd_en, bus.mem_wr_en}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.lsu_err}, 0);
        check("rst_rd_data", bus.ifu_rd_data | bus.lsu_rd_data, 0);
        rst = 1'b0;

        // IFU read 0x80000000
        bus.ifu_valid = 1'b1;
        bus.ifu_addr  = 64'h8000_0000;
        #1;
        check("ifu_rd_ready", {bus.ifu_ready, bus.lsu_ready}, 2'b10);
        tick();
        check("ifu_rd_ready_issue", bus.ifu_ready, 0);
        check("ifu_rd_en", {bus.mem_rd_en, bus.mem_wr_en}, 2'b10);
        check("ifu_rd_addr", bus.mem_addr, 64'h8000_0000);
        bus.ifu_valid = 1'b0;
        tick();
        check("ifu_rd_wait", {bus.mem_rd_en, bus.ifu_resp_valid}, 0);
        tick();
        check("ifu_rd_resp", bus.ifu_resp_valid, 1);
        check("ifu_rd_data", bus.ifu_rd_data, 64'h13);
        check("ifu_rd_addr_hold", bus.mem_addr, 64'h8000_0000);
        tick();
        check("ifu_rd_resp_pulse", bus.ifu_resp_valid, 0);

        // LSU store 0x80000010
        wr0             = wr_cnt;
        bus.lsu_valid   = 1'b1;
        bus.lsu_wr_en   = 1'b1;
        bus.lsu_addr    = 64'h8000_0010;
        bus.lsu_wr_data = 64'hDEAD_BEEF;
        bus.lsu_wr_byt  = 64'(MEM_BYT_4_U);
        #1;
        check("st_ready", {bus.ifu_ready, bus.lsu_ready}, 2'b01);
        tick();
        check("st_en", {bus.mem_rd_en, bus.mem_wr_en}, 2'b01);
        check("st_addr", bus.mem_addr, 64'h8000_0010);
        check("st_data", bus.mem_wr_data, 64'hDEAD_BEEF);
        check("st_byt", bus.mem_wr_byt, 64'd6);
        bus.lsu_valid = 1'b0;
        bus.lsu_wr_en = 1'b0;
        tick();
        check("st_wait_en", {bus.mem_rd_en, bus.mem_wr_en}, 0);
        tick();
        check("st_resp", {bus.lsu_resp_valid, bus.ifu_resp_valid, bus.lsu_err}, 3'b100);
        check("st_rd_data", bus.lsu_rd_data, 0);
        check("st_wr_count", 64'(wr_cnt - wr0), 1);
        tick();

        // Both valid for four transactions: IFU, LSU, IFU, LSU
        rd0            = rd_cnt;
        bus.ifu_valid  = 1'b1;
        bus.ifu_addr   = 64'h8000_0100;
        bus.lsu_valid  = 1'b1;
        bus.lsu_wr_en  = 1'b0;
        bus.lsu_addr   = 64'h8000_0020;
        bus.lsu_wr_byt = 64'(MEM_BYT_8);
        for (int k = 0; k < 4; k++) begin
            exp_ifu = (k % 2 == 0);
            #1;
            check("rr_grant", {bus.ifu_ready, bus.lsu_ready}, {exp_ifu, !exp_ifu});
            tick();
            check("rr_busy_ready", {bus.ifu_ready, bus.lsu_ready}, 0);
            check("rr_rd_en", bus.mem_rd_en, 1);
            check("rr_addr", bus.mem_addr, exp_ifu ? 64'h8000_0100 : 64'h8000_0020);
            tick();
            tick();
            check("rr_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, {exp_ifu, !exp_ifu});
            if (exp_ifu) check("rr_ifu_data", bus.ifu_rd_data, 64'h8000_0100_7FFF_FEFF);
            else         check("rr_lsu_data", bus.lsu_rd_data, 64'h8000_0020_7FFF_FFDF);
            tick();
        end
        bus.ifu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        check("rr_rd_count", 64'(rd_cnt - rd0), 4);
        check("rr_no_dual_en", dual_en, 0);

        // Reset asserted during WAIT
        #1;
        bus.ifu_valid = 1'b1;
        bus.ifu_addr  = 64'h8000_0000;
        tick();
        bus.ifu_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {bus.mem_rd_en, bus.mem_wr_en, bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        check("mid_rst_addr", bus.mem_addr, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_no_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        end
        // last_grant back to LSU: IFU wins the tie, LSU follows
        bus.ifu_valid  = 1'b1;
        bus.ifu_addr   = 64'h8000_0000;
        bus.lsu_valid  = 1'b1;
        bus.lsu_wr_en  = 1'b0;
        bus.lsu_addr   = 64'h8000_0008;
        bus.lsu_wr_byt = 64'(MEM_BYT_8);
        #1;
        check("post_rst_grant", {bus.ifu_ready, bus.lsu_ready}, 2'b10);
        tick();
        check("post_rst_addr", bus.mem_addr, 64'h8000_0000);
        bus.ifu_valid = 1'b0;
        tick();
        tick();
        check("post_rst_ifu_resp", bus.ifu_resp_valid, 1);
        check("post_rst_ifu_data", bus.ifu_rd_data, 64'h13);
        tick();
        check("post_rst_lsu_grant", {bus.ifu_ready, bus.lsu_ready}, 2'b01);
        tick();
        bus.lsu_valid = 1'b0;
        tick();
        tick();
        check("post_rst_lsu_resp", bus.lsu_resp_valid, 1);
        check("post_rst_lsu_data", bus.lsu_rd_data, 64'h8000_0008_7FFF_FFF7);
        tick();

        // Misaligned LSU load 0x80000002, 4-byte
        rd0            = rd_cnt;
        bus.lsu_valid  = 1'b1;
        bus.lsu_wr_en  = 1'b0;
        bus.lsu_addr   = 64'h8000_0002;
        bus.lsu_wr_byt = 64'(MEM_BYT_4_U);
`ifdef MEM_ARB_ALIGN_CHK_EN
        tick();
        bus.lsu_valid = 1'b0;
        for (int i = 0; i < 8 && !bus.lsu_resp_valid; i++) tick();
        check("mis_resp", bus.lsu_resp_valid, 1);
        check("mis_err", bus.lsu_err, 1);
        check("mis_rd_data", bus.lsu_rd_data, 0);
        check("mis_no_rd_en", 64'(rd_cnt - rd0), 0);
`else
        tick();
        check("mis_rd_en", bus.mem_rd_en, 1);
        check("mis_addr", bus.mem_addr, 64'h8000_0002);
        bus.lsu_valid = 1'b0;
        tick();
        tick();
        check("mis_resp", {bus.lsu_resp_valid, bus.lsu_err}, 2'b10);
        check("mis_rd_data", bus.lsu_rd_data, 64'h8000_0002_7FFF_FFFD);
        check("mis_rd_count", 64'(rd_cnt - rd0), 1);
`endif
        tick();
        tick();
        check("end_no_dual_en", dual_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
